// File: rtl/spi_tx_if.sv
// Signal bundle between control logic and the spi_tx SPI mode-0 transmitter.
// master: the transmitter side; slave: the controlling/observing side.
interface spi_tx_if;
   logic       onoff;
   logic [7:0] data_in;
   logic       cs;
   logic       scl;
   logic       sda;
   logic       valid;

   modport master (
      input  onoff,
      input  data_in,
      output cs,
      output scl,
      output sda,
      output valid
   );

   modport slave (
      output onoff,
      output data_in,
      input  cs,
      input  scl,
      input  sda,
      input  valid
   );
endinterface

// File: rtl/spi_tx.sv
// Write-only SPI mode-0 master: 8-bit frames, scl = clk/(2*HALF), one valid pulse per byte.
// Define SPI_LSB_FIRST_EN to shift LSB first (default MSB first); timing is identical.
module spi_tx #(
   parameter int unsigned HALF = 5
) (
   input  logic      clk,
   input  logic      reset,
   spi_tx_if.master  bus
);

   localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      DONE
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     shreg_q, shreg_d;
   logic           cs_q, cs_d;
   logic           scl_q, scl_d;
   logic           sda_q, sda_d;
   logic           valid_q, valid_d;
   logic           tick;

   assign tick = (cnt_q == CW'(HALF - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         cs_q    <= 1'b1;
         scl_q   <= 1'b0;
         sda_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         cs_q    <= cs_d;
         scl_q   <= scl_d;
         sda_q   <= sda_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      cs_d    = cs_q;
      scl_d   = scl_q;
      valid_d = 1'b0;

      if (state_q != IDLE) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            cs_d  = 1'b1;
            scl_d = 1'b0;
            if (bus.onoff) begin
               shreg_d = bus.data_in;
               bit_d   = '0;
               cs_d    = 1'b0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (tick) begin
               scl_d   = 1'b1;
               state_d = HIGH;
            end
         end
         HIGH: begin
            if (tick) begin
               scl_d = 1'b0;
               if (bit_q == 3'd7) begin
                  // valid and cs release land on the same edge that enters DONE
                  valid_d = 1'b1;
                  cs_d    = 1'b1;
                  state_d = DONE;
               end else begin
`ifdef SPI_LSB_FIRST_EN
                  shreg_d = {1'b0, shreg_q[7:1]};
`else
                  shreg_d = {shreg_q[6:0], 1'b0};
`endif
                  bit_d   = bit_q + 3'd1;
                  state_d = LOW;
               end
            end
         end
         LOW: begin
            if (tick) begin
               scl_d   = 1'b1;
               state_d = HIGH;
            end
         end
         DONE: begin
            if (tick) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // sda is registered from the next-state shift register so it tracks cs exactly
`ifdef SPI_LSB_FIRST_EN
      sda_d = cs_d ? 1'b0 : shreg_d[0];
`else
      sda_d = cs_d ? 1'b0 : shreg_d[7];
`endif
   end

   assign bus.cs    = cs_q;
   assign bus.scl   = scl_q;
   assign bus.sda   = sda_q;
   assign bus.valid = valid_q;

endmodule

// File: tb/tb_spi_tx.sv
// Self-checking bench for spi_tx: table-driven frames, hand-written corner sequences and
// randomized enable/data traffic checked by a sampling reference model of the SPI frame.
module tb_spi_tx;

   localparam int HALF = 5;

   logic clk = 1'b0;
   logic reset = 1'b0;

   spi_tx_if bus();

   spi_tx #(.HALF(HALF)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // order in which the byte's bits must appear at the rising scl edges
   function automatic logic [7:0] wire_order(input logic [7:0] b);
      logic [7:0] r;
`ifdef SPI_LSB_FIRST_EN
      for (int i = 0; i < 8; i++) r[7-i] = b[i];
`else
      r = b;
`endif
      return r;
   endfunction

   // ---------------- reference model / monitor ----------------
   logic       cs_p = 1'b1, scl_p = 1'b0, sda_p = 1'b0, valid_p = 1'b0;
   bit         in_frame = 1'b0;
   int         fcyc = 0, nbits = 0, gap_cnt = HALF, last_gap = 0;
   int         frame_starts = 0, frames_done = 0;
   logic [7:0] exp_seq = '0, obs_seq = '0, last_seq = '0;

   always @(posedge clk) begin
      #1;
      if (!reset) begin
         chk("rst_cs", bus.cs, 1'b1);
         chk("rst_scl", bus.scl, 1'b0);
         chk("rst_sda", bus.sda, 1'b0);
         chk("rst_valid", bus.valid, 1'b0);
         in_frame = 1'b0;
         cs_p = 1'b1; scl_p = 1'b0; sda_p = 1'b0; valid_p = 1'b0;
         gap_cnt = HALF;
      end else begin
         gap_cnt++;
         if (in_frame) fcyc++;
         if (bus.cs) begin
            chk("scl_low_while_cs_high", bus.scl, 1'b0);
            chk("sda_low_while_cs_high", bus.sda, 1'b0);
         end
         // idle long enough and enabled at this edge: a frame must have started
         if (cs_p && bus.onoff && gap_cnt >= HALF + 1)
            chk("start_when_enabled", bus.cs, 1'b0);
         if (scl_p && bus.scl)
            chk("sda_stable_scl_high", bus.sda, sda_p);
         if (cs_p && !bus.cs) begin
            chk("gap_min", 32'(gap_cnt >= HALF + 1), 1);
            last_gap = gap_cnt;
            in_frame = 1'b1;
            fcyc = 0;
            nbits = 0;
            obs_seq = '0;
            exp_seq = wire_order(bus.data_in);
            frame_starts++;
         end
         if (!scl_p && bus.scl) begin
            chk("scl_rise_in_frame", 32'(in_frame), 1);
            chk("scl_rise_time", fcyc, HALF + 2 * HALF * nbits);
            obs_seq = {obs_seq[6:0], bus.sda};
            nbits++;
         end
         if (!cs_p && bus.cs)
            chk("valid_with_cs_rise", bus.valid, 1'b1);
         if (bus.valid) begin
            chk("valid_single", valid_p, 1'b0);
            chk("valid_cs_rise", {cs_p, bus.cs}, 2'b01);
            chk("valid_in_frame", 32'(in_frame), 1);
            chk("valid_latency", fcyc, 16 * HALF);
            chk("bit_count", nbits, 8);
            chk("frame_data", obs_seq, exp_seq);
            last_seq = obs_seq;
            frames_done++;
            in_frame = 1'b0;
         end
         if (!cs_p && bus.cs) gap_cnt = 0;
         cs_p = bus.cs;
         scl_p = bus.scl;
         sda_p = bus.sda;
         valid_p = bus.valid;
      end
   end

   // ---------------- bounded waits ----------------
   task automatic wait_starts(input int target, input string what);
      for (int i = 0; i < 400; i++) begin
         if (frame_starts >= target) break;
         @(negedge clk);
      end
      chk({"start_", what}, 32'(frame_starts >= target), 1);
   endtask

   task automatic wait_done(input int target, input string what);
      for (int i = 0; i < 400; i++) begin
         if (frames_done >= target) break;
         @(negedge clk);
      end
      chk({"done_", what}, 32'(frames_done >= target), 1);
   endtask

   task automatic wait_bits(input int n, input string what);
      for (int i = 0; i < 400; i++) begin
         if (in_frame && nbits >= n) break;
         @(negedge clk);
      end
      chk({"bits_", what}, 32'(in_frame && nbits >= n), 1);
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [7:0] din;
      logic [7:0] msb_seq;
      logic [7:0] lsb_seq;
   } vec_t;

   vec_t tbl[8];

   function automatic logic [7:0] pick(input vec_t v);
`ifdef SPI_LSB_FIRST_EN
      return v.lsb_seq;
`else
      return v.msb_seq;
`endif
   endfunction

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, d, s, base, sbase, exp_win, exp_starts, done0;
      logic [7:0] e2_seq, a5_seq;

      tbl[0] = '{8'hE2, 8'hE2, 8'h47};
      tbl[1] = '{8'h5A, 8'h5A, 8'h5A};
      tbl[2] = '{8'h01, 8'h01, 8'h80};
      tbl[3] = '{8'h80, 8'h80, 8'h01};
      tbl[4] = '{8'hFF, 8'hFF, 8'hFF};
      tbl[5] = '{8'h00, 8'h00, 8'h00};
      tbl[6] = '{8'hC1, 8'hC1, 8'h83};
      tbl[7] = '{8'h36, 8'h36, 8'h6C};
      e2_seq = pick(tbl[0]);
      a5_seq = pick(tbl[1]);

      // reset held with enable high, then release
      reset = 1'b0;
      bus.onoff = 1'b1;
      bus.data_in = 8'hE2;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("cs_falls_after_reset", bus.cs, 1'b0);
      @(negedge clk);
      bus.onoff = 1'b0;
      wait_done(1, "first");
      chk("first_frame_e2", last_seq, e2_seq);

      // table: one frame per row; enable re-raised during DONE
      foreach (tbl[k]) begin
         @(negedge clk);
         bus.data_in = tbl[k].din;
         bus.onoff = 1'b1;
         t = frame_starts + 1;
         wait_starts(t, "tbl");
         bus.onoff = 1'b0;
         wait_done(t, "tbl");
         chk("table_seq", last_seq, pick(tbl[k]));
      end

      // enable held for 2000 ns
      repeat (HALF + 3) @(negedge clk);
      bus.data_in = 8'hE2;
      base = frames_done;
      sbase = frame_starts;
      exp_win = 0;
      exp_starts = 0;
      for (int k = 0; k < 10; k++) begin
         if (k * (17 * HALF + 1) + 16 * HALF <= 199) exp_win++;
         if (k * (17 * HALF + 1) <= 199) exp_starts++;
      end
      bus.onoff = 1'b1;
      repeat (200) @(negedge clk);
      chk("valid_in_2000ns", frames_done - base, exp_win);
      bus.onoff = 1'b0;
      wait_done(base + exp_starts, "b2b");
      chk("b2b_frames", frame_starts - sbase, exp_starts);
      chk("b2b_gap", last_gap, HALF + 1);
      chk("b2b_data", last_seq, e2_seq);
      s = frame_starts;
      repeat (100) @(negedge clk);
      chk("idle_no_frame", frame_starts, s);
      chk("idle_cs", bus.cs, 1'b1);
      chk("idle_scl", bus.scl, 1'b0);
      chk("idle_sda", bus.sda, 1'b0);

      // enable dropped after the 3rd rising scl edge
      bus.data_in = 8'hC1;
      bus.onoff = 1'b1;
      t = frame_starts + 1;
      wait_starts(t, "drop");
      wait_bits(3, "drop");
      bus.onoff = 1'b0;
      wait_done(t, "drop");
      chk("drop_seq", last_seq, pick(tbl[6]));
      repeat (100) @(negedge clk);
      chk("drop_no_new_frame", frame_starts, t);

      // data_in changed mid-frame
      bus.data_in = 8'hE2;
      bus.onoff = 1'b1;
      t = frame_starts + 1;
      wait_starts(t, "chg");
      wait_bits(2, "chg");
      bus.data_in = 8'h5A;
      wait_done(t, "chg0");
      chk("chg_first_frame", last_seq, e2_seq);
      wait_starts(t + 1, "chg1");
      bus.onoff = 1'b0;
      wait_done(t + 1, "chg1");
      chk("chg_second_frame", last_seq, a5_seq);
      repeat (HALF + 3) @(negedge clk);

      // asynchronous reset mid-frame
      bus.data_in = 8'($urandom);
      bus.onoff = 1'b1;
      t = frame_starts + 1;
      wait_starts(t, "rst");
      wait_bits(4, "rst");
      d = frames_done;
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_cs", bus.cs, 1'b1);
      chk("async_rst_scl", bus.scl, 1'b0);
      chk("async_rst_sda", bus.sda, 1'b0);
      chk("async_rst_valid", bus.valid, 1'b0);
      bus.onoff = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      chk("rst_no_valid", frames_done, d);
      chk("rst_no_restart", frame_starts, t);

      // randomized enable and data traffic
      done0 = frames_done;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 19) == 0) bus.data_in = 8'($urandom);
         if ($urandom_range(0, 49) == 0) bus.onoff = ~bus.onoff;
      end
      bus.onoff = 1'b0;
      repeat (200) @(negedge clk);
      chk("random_quiescent", 32'(in_frame), 0);
      chk("random_frames_seen", 32'(frames_done > done0), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
